// File: rtl/nn_rnn_pkg.sv
// Shared types and saturation limits for the RNN backprop gradient path.
package nn_rnn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Symmetric saturation limits for an nb-bit signed count (nb <= 31).
  // The most negative two's complement code is deliberately excluded.
  function automatic int sat_max(input int nb);
    return (2 ** (nb - 1)) - 1;
  endfunction

  function automatic int sat_min(input int nb);
    return -((2 ** (nb - 1)) - 1);
  endfunction

endpackage

// File: rtl/nn_grad_acc.sv
// One gradient channel: stochastic AND, registered gradient bit and a
// signed, symmetric-saturating up/down counter with clear and enable.
module nn_grad_acc
  import nn_rnn_pkg::*;
#(
  parameter int NB = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic                 i_delta,
  input  logic                 i_sgn,
  input  logic                 i_a,
  output logic                 o_g,
  output logic signed [NB-1:0] o_acc_nxt
);

  localparam logic signed [NB-1:0] ACC_MAX = NB'(sat_max(NB));
  localparam logic signed [NB-1:0] ACC_MIN = NB'(sat_min(NB));
  localparam logic signed [NB-1:0] ONE     = NB'(1);

  logic                 w_g;
  logic signed [NB-1:0] r_acc;

  // One step toward the sign of delta, clamped at the symmetric limits.
  function automatic logic signed [NB-1:0] sat_step(input logic signed [NB-1:0] v,
                                                     input logic dn);
    logic signed [NB-1:0] res;
    if (dn) res = (v == ACC_MIN) ? v : v - ONE;
    else    res = (v == ACC_MAX) ? v : v + ONE;
    return res;
  endfunction

  assign w_g = i_en & i_delta & i_a;

  // Next accumulator value; exported so the top can capture the window's
  // final count on the same edge that accepts the last sample.
  always_comb begin
    o_acc_nxt = r_acc;
    if (i_clr)    o_acc_nxt = '0;
    else if (w_g) o_acc_nxt = sat_step(r_acc, i_sgn);
  end

  // Accumulator and registered magnitude-only gradient bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
      o_g   <= 1'b0;
    end else begin
      r_acc <= o_acc_nxt;
      o_g   <= w_g;
    end
  end

endmodule

// File: rtl/nn_rnn_dnode_acc.sv
// Recurrent backprop node: forms alpha/gamma/beta stochastic gradient bits
// and accumulates them over one BPTT window of NT * 2^LW valid samples,
// publishing the final counts with a one-cycle done pulse.
module nn_rnn_dnode_acc
  import nn_rnn_pkg::*;
#(
  parameter int NB = 16,
  parameter int NN = 3,
  parameter int NR = 3,
  parameter int NT = 6,
  parameter int LW = 8
) (
  input  logic             CLK,
  input  logic             INIT,
  input  logic             start,
  input  logic             in_valid,
  input  logic             delta,
  input  logic             delta_sgn,
  input  logic [NN-1:0]    atj,
  input  logic [NR-1:0]    atj_last,
  output logic [NN-1:0]    dalpha,
  output logic [NR-1:0]    dgamma,
  output logic             dbeta,
  output logic [NN*NB-1:0] dalpha_cnt,
  output logic [NR*NB-1:0] dgamma_cnt,
  output logic [NB-1:0]    dbeta_cnt,
  output logic             busy,
  output logic             done
);

  localparam int SW = (NT > 1) ? $clog2(NT) : 1;

  state_t           r_st;
  state_t           w_st_nxt;
  logic [LW-1:0]    r_samp;
  logic [SW-1:0]    r_step;
  logic             w_clr;
  logic             w_en;
  logic             w_last;
  logic [NN*NB-1:0] w_alpha_nxt;
  logic [NR*NB-1:0] w_gamma_nxt;
  logic [NB-1:0]    w_beta_nxt;
  logic [NN*NB-1:0] r_alpha_cnt;
  logic [NR*NB-1:0] r_gamma_cnt;
  logic [NB-1:0]    r_beta_cnt;

  assign w_clr  = (r_st == ST_IDLE) && start;
  assign w_en   = (r_st == ST_ACC) && in_valid;
  assign w_last = w_en && (r_step == SW'(NT - 1)) && (&r_samp);

  assign busy       = (r_st == ST_ACC);
  assign done       = (r_st == ST_DONE);
  assign dalpha_cnt = r_alpha_cnt;
  assign dgamma_cnt = r_gamma_cnt;
  assign dbeta_cnt  = r_beta_cnt;

  // Window state register.
  always_ff @(posedge CLK or negedge INIT) begin
    if (!INIT) r_st <= ST_IDLE;
    else       r_st <= w_st_nxt;
  end

  // Next state: start only honoured in IDLE; DONE always lasts one cycle.
  always_comb begin
    w_st_nxt = r_st;
    case (r_st)
      ST_IDLE: if (start)  w_st_nxt = ST_ACC;
      ST_ACC:  if (w_last) w_st_nxt = ST_DONE;
      ST_DONE: w_st_nxt = ST_IDLE;
      default: w_st_nxt = ST_IDLE;
    endcase
  end

  // Sample/step position within the window; sample wraps into step.
  always_ff @(posedge CLK or negedge INIT) begin
    if (!INIT) begin
      r_samp <= '0;
      r_step <= '0;
    end else if (w_clr) begin
      r_samp <= '0;
      r_step <= '0;
    end else if (w_en) begin
      r_samp <= r_samp + 1'b1;
      if (&r_samp) r_step <= r_step + 1'b1;
    end
  end

  // Publish counts, including the last sample, on the edge entering DONE.
  always_ff @(posedge CLK or negedge INIT) begin
    if (!INIT) begin
      r_alpha_cnt <= '0;
      r_gamma_cnt <= '0;
      r_beta_cnt  <= '0;
    end else if (w_last) begin
      r_alpha_cnt <= w_alpha_nxt;
      r_gamma_cnt <= w_gamma_nxt;
      r_beta_cnt  <= w_beta_nxt;
    end
  end

  for (genvar n = 0; n < NN; n++) begin : g_alpha
    nn_grad_acc #(.NB(NB)) u_acc (
      .i_clk     (CLK),
      .i_rst_n   (INIT),
      .i_clr     (w_clr),
      .i_en      (w_en),
      .i_delta   (delta),
      .i_sgn     (delta_sgn),
      .i_a       (atj[n]),
      .o_g       (dalpha[n]),
      .o_acc_nxt (w_alpha_nxt[n*NB +: NB])
    );
  end

  for (genvar r = 0; r < NR; r++) begin : g_gamma
    nn_grad_acc #(.NB(NB)) u_acc (
      .i_clk     (CLK),
      .i_rst_n   (INIT),
      .i_clr     (w_clr),
      .i_en      (w_en),
      .i_delta   (delta),
      .i_sgn     (delta_sgn),
      .i_a       (atj_last[r]),
      .o_g       (dgamma[r]),
      .o_acc_nxt (w_gamma_nxt[r*NB +: NB])
    );
  end

  nn_grad_acc #(.NB(NB)) u_beta (
    .i_clk     (CLK),
    .i_rst_n   (INIT),
    .i_clr     (w_clr),
    .i_en      (w_en),
    .i_delta   (delta),
    .i_sgn     (delta_sgn),
    .i_a       (1'b1),
    .o_g       (dbeta),
    .o_acc_nxt (w_beta_nxt)
  );

endmodule

// File: doc/nn_rnn_dnode_acc.md
# nn_rnn_dnode_acc

Parametrised recurrent backpropagation node that forms stochastic gradient bits (delta AND activation) for the feed-forward weights (alpha), the recurrent weights (gamma) and the bias (beta). It also accumulates them into signed, saturating gradient counts over a full backprop-through-time window of NT time steps × 2^LW stream samples. It sits between the delta generator of an RNN layer and the weight-update unit. The weight-update unit consumes the counts once per window via a start/done handshake.

## Interface
Parameters:
- NB, 16: accumulator width (signed, two's complement).
- NN, 3: nodes in previous layer (alpha channels).
- NR, 3: nodes in current layer (gamma channels).
- NT, 6: time steps per BPTT window (memory depth).
- LW, 8: log2 of stochastic stream length per time step.

Ports:
- CLK  in  1  clock, all state on rising edge.
- INIT  in  1  reset, asynchronous, active-low.
- start  in  1  begin new accumulation window.
- in_valid  in  1  stream sample valid this cycle.
- delta  in  1  stochastic magnitude bit of dC/dz.
- delta_sgn  in  1  sign of delta for current sample (1 = negative).
- atj  in  NN  previous-layer activation bits.
- atj_last  in  NR  current-layer activation bits from previous time step.
- dalpha  out  NN  registered gradient bits, alpha.
- dgamma  out  NR  registered gradient bits, gamma.
- dbeta  out  1  registered gradient bit, beta.
- dalpha_cnt  out  NN*NB  packed signed alpha counts, channel n at [n*NB +: NB].
- dgamma_cnt  out  NR*NB  packed signed gamma counts.
- dbeta_cnt  out  NB  signed beta count.
- busy  out  1  window in progress.
- done  out  1  one-cycle pulse, counts final.

## Operation
- FSM states: IDLE, ACC, DONE.
- Reset (INIT low, any time including mid-window): state IDLE; all counts, internal sample/step counters, dalpha/dgamma/dbeta, busy and done are 0.
- IDLE:
  - start=1 → ACC.
  - On the same edge, internal accumulators and the sample/step counters clear to 0.
  - Published *_cnt outputs keep their previous values until DONE.
- ACC, each cycle with in_valid=1:
  - Gradient bit g = delta & a for each channel; g = delta for beta.
  - If g=1, the channel accumulator is incremented (delta_sgn=0) or decremented (delta_sgn=1).
  - Increment/decrement saturates at +(2^(NB-1)-1) / -(2^(NB-1)-1). Never wraps; the most negative code is never produced.
  - Sample counter increments. At 2^LW-1 it wraps to 0 and the step counter increments.
- ACC with in_valid=0: nothing changes; gradient bit outputs drop to 0.
- When the last sample is accepted (step = NT-1 and sample = 2^LW-1 with in_valid=1), the next state is DONE.
- DONE lasts one cycle: done=1, busy=0. Next state is IDLE.
- *_cnt outputs are updated with accumulator values on the edge entering DONE and are held until the next DONE or reset.
- start is ignored while in ACC or DONE. A start pulse in the DONE cycle is lost; the sender must wait for IDLE.
- busy=1 exactly in ACC.

## Timing
- dalpha/dgamma/dbeta: 1-cycle latency from inputs.
  - Output = delta & a registered, gated by in_valid and busy.
  - These outputs carry magnitude only; the sign is not propagated.
- Window length: exactly NT·2^LW valid cycles. Invalid cycles stretch the window.
- done asserts on the cycle after the final valid sample. The *_cnt outputs are valid on that same cycle.
- Minimum start-to-start period: NT·2^LW + 2 cycles.

## Structure
- Shared package nn_rnn_pkg:
  - FSM state enum.
  - Saturation limit constants derived from NB.
- Sub-module nn_grad_acc: one channel, consisting of:
  - AND gate;
  - registered gradient bit;
  - signed saturating up/down accumulator with clear and enable.
- nn_grad_acc is instantiated NN+NR+1 times. The top holds the FSM, counters and the output capture registers.

## Test plan
- Reset mid-ACC (NT=2, LW=2, after 3 samples):
  - busy, done, all counts and gradient bits → 0 immediately.
  - A later start begins a clean window.
- Full window, NN=NR=1, delta=1, sgn=0, atj=1, atj_last=0, in_valid=1 constant:
  - done after 8 valid cycles (NT=2, LW=2).
  - dalpha_cnt=8, dgamma_cnt=0, dbeta_cnt=8.
- Sign alternation (delta_sgn toggling each sample, all activations 1):
  - All counts = 0 at done.
  - dbeta bit stream is 1 every valid cycle.
- Saturation, NB=4, NT=4, LW=2, all ones, sgn=0:
  - Counts clamp at +7.
  - With sgn=1 they clamp at -7, never -8.
- in_valid gaps (valid every other cycle, NT=1, LW=2):
  - done arrives on the cycle after the 4th valid sample.
  - Gradient bits are 0 on invalid cycles.
- start asserted during ACC and during DONE: no restart. Counts reflect only the original window.
